// File: rtl/sram_arbiter.sv
// Round-robin read arbiter that owns the single read port of the sram block.
// Accepts at most one request per cycle; the read word returns tagged two edges later.
module sram_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_adr,
  input  logic                 hold,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        sram_adr,
  input  logic [DW-1:0]        sram_data,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   sram_adr_q, sram_adr_d;
  logic            va_q, va_d;
  logic [NREQ-1:0] taga_q, taga_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   win_c;
  logic            any_c;

  // First set request searching upward from ptr with wrap; forced idle in reset or hold.
  always_comb begin : arb
    logic [PW-1:0] idx;
    gnt_c = '0;
    win_c = '0;
    any_c = 1'b0;
    idx   = '0;
    if (rst_n && !hold) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = PW'((32'(ptr_q) + k) % NREQ);
        if (!any_c && req[idx]) begin
          any_c      = 1'b1;
          win_c      = idx;
          gnt_c[idx] = 1'b1;
        end
      end
    end
  end

  // Next-state for pointer and the two-stage read pipeline.
  always_comb begin
    ptr_d      = ptr_q;
    sram_adr_d = sram_adr_q;
    va_d       = 1'b0;
    taga_d     = taga_q;
    rvalid_d   = va_q ? taga_q : '0;
    if (any_c) begin
      ptr_d      = (32'(win_c) == NREQ - 1) ? '0 : win_c + PW'(1);
      sram_adr_d = req_adr[32'(win_c) * AW +: AW];
      taga_d     = gnt_c;
      va_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      sram_adr_q <= '0;
      va_q       <= 1'b0;
      taga_q     <= '0;
      rvalid_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      sram_adr_q <= sram_adr_d;
      va_q       <= va_d;
      taga_q     <= taga_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign gnt      = gnt_c;
  assign sram_adr = sram_adr_q;
  assign rvalid   = rvalid_q;
  // sram output is already aligned with rvalid, so it passes straight through.
  assign rdata    = sram_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vector table plus reset, hold and random fairness sequences for sram_arbiter,
// with a registered-read sram model holding mem[a] = 32'hA5A5_0000 + a.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [19:0] req_adr;
  logic        hold;
  logic [3:0]  gnt;
  logic [4:0]  sram_adr;
  logic [31:0] sram_data;
  logic [3:0]  rvalid;
  logic [31:0] rdata;

  int n_pass;
  int n_total;

  sram_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_adr  (req_adr),
    .hold     (hold),
    .gnt      (gnt),
    .sram_adr (sram_adr),
    .sram_data(sram_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [4:0] a);
    return 32'hA5A5_0000 + 32'(a);
  endfunction

  always @(posedge clk) sram_data <= mem(sram_adr);

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [19:0] adr;
    logic        hold;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic [4:0]  sadr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic [19:0] a, input logic h,
                              input logic [3:0] g, input logic [3:0] rv,
                              input logic [31:0] rd, input logic [4:0] sa);
    vec_t v;
    v.req = r; v.adr = a; v.hold = h; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.sadr = sa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  vec_t v[34];

  initial begin
    logic [19:0] c;
    logic [3:0]  pend;
    logic [4:0]  fadr[4];
    int          wt[4];
    int          mptr;
    logic [3:0]  eg;
    logic [3:0]  p1_tag, p2_tag;
    logic [4:0]  p1_adr, p2_adr;
    logic [4:0]  wadr;
    int          gw;

    n_pass = 0; n_total = 0;
    c = pk(10, 11, 12, 13);
    // contention from reset
    v[0]  = mk(4'b1111, c, 0, 4'b0001, 4'b0000, 0,            0);
    v[1]  = mk(4'b1111, c, 0, 4'b0010, 4'b0000, 0,            10);
    v[2]  = mk(4'b1111, c, 0, 4'b0100, 4'b0001, 32'hA5A5000A, 11);
    v[3]  = mk(4'b1111, c, 0, 4'b1000, 4'b0010, 32'hA5A5000B, 12);
    v[4]  = mk(4'b1111, c, 0, 4'b0001, 4'b0100, 32'hA5A5000C, 13);
    v[5]  = mk(4'b1111, c, 0, 4'b0010, 4'b1000, 32'hA5A5000D, 10);
    v[6]  = mk(4'b0000, c, 0, 4'b0000, 4'b0001, 32'hA5A5000A, 11);
    v[7]  = mk(4'b0000, c, 0, 4'b0000, 4'b0010, 32'hA5A5000B, 11);
    v[8]  = mk(4'b0000, c, 0, 4'b0000, 4'b0000, 0,            11);
    // single requester, address 5
    v[9]  = mk(4'b0100, pk(0, 0, 5, 0), 0, 4'b0100, 4'b0000, 0, 11);
    v[10] = mk(4'b0000, pk(0, 0, 5, 0), 0, 4'b0000, 4'b0000, 0, 5);
    v[11] = mk(4'b0000, pk(0, 0, 5, 0), 0, 4'b0000, 4'b0100, 32'hA5A50005, 5);
    v[12] = mk(4'b0000, pk(0, 0, 5, 0), 0, 4'b0000, 4'b0000, 0, 5);
    // back-to-back requester 2: 31, 0, 1
    v[13] = mk(4'b0100, pk(0, 0, 31, 0), 0, 4'b0100, 4'b0000, 0, 5);
    v[14] = mk(4'b0100, pk(0, 0, 0, 0),  0, 4'b0100, 4'b0000, 0, 31);
    v[15] = mk(4'b0100, pk(0, 0, 1, 0),  0, 4'b0100, 4'b0100, 32'hA5A5001F, 0);
    v[16] = mk(4'b0000, pk(0, 0, 1, 0),  0, 4'b0000, 4'b0100, 32'hA5A50000, 1);
    v[17] = mk(4'b0000, pk(0, 0, 1, 0),  0, 4'b0000, 4'b0100, 32'hA5A50001, 1);
    v[18] = mk(4'b0000, pk(0, 0, 1, 0),  0, 4'b0000, 4'b0000, 0, 1);
    // hold for 3 cycles right after accepting requester 0
    v[19] = mk(4'b0001, pk(3, 17, 0, 0), 0, 4'b0001, 4'b0000, 0, 1);
    v[20] = mk(4'b0011, pk(3, 17, 0, 0), 1, 4'b0000, 4'b0000, 0, 3);
    v[21] = mk(4'b0011, pk(3, 17, 0, 0), 1, 4'b0000, 4'b0001, 32'hA5A50003, 3);
    v[22] = mk(4'b0011, pk(3, 17, 0, 0), 1, 4'b0000, 4'b0000, 0, 3);
    v[23] = mk(4'b0011, pk(3, 17, 0, 0), 0, 4'b0010, 4'b0000, 0, 3);
    v[24] = mk(4'b0001, pk(3, 17, 0, 0), 0, 4'b0001, 4'b0000, 0, 17);
    v[25] = mk(4'b0000, pk(3, 17, 0, 0), 0, 4'b0000, 4'b0010, 32'hA5A50011, 3);
    v[26] = mk(4'b0000, pk(3, 17, 0, 0), 0, 4'b0000, 4'b0001, 32'hA5A50003, 3);
    v[27] = mk(4'b0000, pk(3, 17, 0, 0), 0, 4'b0000, 4'b0000, 0, 3);
    // immediate re-request loses to another pending requester
    v[28] = mk(4'b0010, pk(4, 9, 0, 0), 0, 4'b0010, 4'b0000, 0, 3);
    v[29] = mk(4'b0011, pk(4, 9, 0, 0), 0, 4'b0001, 4'b0000, 0, 9);
    v[30] = mk(4'b0010, pk(4, 9, 0, 0), 0, 4'b0010, 4'b0010, 32'hA5A50009, 4);
    v[31] = mk(4'b0000, pk(4, 9, 0, 0), 0, 4'b0000, 4'b0001, 32'hA5A50004, 9);
    v[32] = mk(4'b0000, pk(4, 9, 0, 0), 0, 4'b0000, 4'b0010, 32'hA5A50009, 9);
    v[33] = mk(4'b0000, pk(4, 9, 0, 0), 0, 4'b0000, 4'b0000, 0, 9);

    // reset state, with requests present
    rst_n = 1'b0; req = 4'b1111; req_adr = c; hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_sram_adr", 32'(sram_adr), 0);
    req = 4'b0000; rst_n = 1'b1;

    foreach (v[i]) begin
      @(negedge clk);
      req = v[i].req; req_adr = v[i].adr; hold = v[i].hold;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v[i].rvalid));
      chk($sformatf("v%0d_sram_adr", i), 32'(sram_adr), 32'(v[i].sadr));
      if (v[i].rvalid != 4'b0000) chk($sformatf("v%0d_rdata", i), rdata, v[i].rdata);
    end

    // reset mid-flight: requester 3 address 7 accepted, reset before its data returns
    @(negedge clk);
    req = 4'b1000; req_adr = pk(0, 0, 0, 7); hold = 1'b0;
    #1 chk("mf_gnt", 32'(gnt), 32'(4'b1000));
    @(negedge clk);
    req = 4'b1001; req_adr = pk(6, 0, 0, 7);
    rst_n = 1'b0;
    #1;
    chk("mf_rvalid_now", 32'(rvalid), 0);
    chk("mf_sram_adr", 32'(sram_adr), 0);
    chk("mf_gnt_in_rst", 32'(gnt), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mf_rvalid_rst%0d", k), 32'(rvalid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mf_gnt_ptr0", 32'(gnt), 32'(4'b0001));
    chk("mf_rvalid_rel", 32'(rvalid), 0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("mf_rvalid_a", 32'(rvalid), 0);
    chk("mf_sram_adr6", 32'(sram_adr), 6);
    @(negedge clk); #1;
    chk("mf_rvalid_b", 32'(rvalid), 32'(4'b0001));
    chk("mf_rdata_b", rdata, 32'hA5A50006);
    @(negedge clk); #1;
    chk("mf_rvalid_c", 32'(rvalid), 0);

    // fairness: requester 0 always requests, others randomly, for 1000 cycles
    @(negedge clk);
    req = 4'b0000; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend = 4'b0000; mptr = 0;
    p1_tag = '0; p2_tag = '0; p1_adr = '0; p2_adr = '0;
    for (int i = 0; i < 4; i++) begin fadr[i] = '0; wt[i] = 0; end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && (i == 0 || $urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          fadr[i] = 5'($urandom_range(0, 31));
        end
      end
      req = pend;
      req_adr = {fadr[3], fadr[2], fadr[1], fadr[0]};
      #1;
      eg = '0; wadr = '0;
      for (int k = 0; k < 4; k++) begin
        if (eg == 4'b0000 && pend[(mptr + k) % 4]) begin
          eg[(mptr + k) % 4] = 1'b1;
          wadr = fadr[(mptr + k) % 4];
          mptr = (mptr + k + 1) % 4;
        end
      end
      chk("fair_gnt", 32'(gnt), 32'(eg));
      chk("fair_rvalid", 32'(rvalid), 32'(p2_tag));
      if (p2_tag != 4'b0000) chk("fair_rdata", rdata, mem(p2_adr));
      gw = -1;
      for (int i = 0; i < 4; i++) if (gnt[i]) gw = i;
      if (gw >= 0) begin
        chk("fair_wait", 32'(wt[gw] < 4), 1);
        wt[gw] = 0;
        for (int i = 0; i < 4; i++) if (pend[i] && i != gw) wt[i]++;
      end
      pend = pend & ~eg;
      p2_tag = p1_tag; p2_adr = p1_adr;
      p1_tag = eg;     p1_adr = wadr;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin read arbiter that shares the single read port of the 32×32 `sram` block among `NREQ` requesters. Each requester presents an address with a request, and the arbiter accepts at most one request per cycle. It drives the SRAM address register and returns the read word, tagged to the winner, two cycles after acceptance. It sits directly in front of `sram` (`clk`, `adr`, data out) and owns that port exclusively.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `AW`, default 5: address width; must match the `sram` depth of 32.
- `DW`, default 32: data width; must match the `sram` word.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, `NREQ`: per-requester request; requester i holds `req[i]` and its address stable until accepted.
- `req_adr`, input, `NREQ*AW`: packed addresses; requester i uses bits `[i*AW +: AW]`.
- `hold`, input, 1: while 1, no request is accepted. In-flight reads still complete.
- `gnt`, output, `NREQ`: combinational one-hot acceptance. A request is accepted on the edge where `req[i]&gnt[i]`.
- `sram_adr`, output, `AW`: registered address to `sram.adr`.
- `sram_data`, input, `DW`: `sram` read data, valid in the cycle after the address edge.
- `rvalid`, output, `NREQ`: one-hot, registered; marks the owner of `rdata` this cycle.
- `rdata`, output, `DW`: equals `sram_data`; meaningful only when `|rvalid`.

## Operation
- Arbitration:
  - `gnt` = 0 when `hold`=1 or `req`=0.
  - Otherwise `gnt` is a one-hot on the first set `req` bit, searching upward, with wrap-around, from index `ptr`.
- Pointer:
  - On an accepted request from requester w, `ptr <= (w+1) mod NREQ`.
  - With no acceptance, `ptr` holds.
  - Fairness guarantee: a continuously requesting requester is accepted within `NREQ` accepting cycles.
- Pipeline, 2 stages:
  - Stage A, on the acceptance edge: `sram_adr <= req_adr[w]`, `tagA <= onehot(w)`, `vA <= 1`.
  - Stage B, on the next edge: `rvalid <= vA ? tagA : 0`.
  - `sram` captures `sram_adr` on the same edge, so `rdata`=`sram_data` is the correct word while `rvalid` is high.
- No acceptance: `vA <= 0` and `sram_adr` holds its last value. No spurious `rvalid` is produced even though `sram` keeps re-reading.
- Addresses are full-range 0..31 with no bounds check. Address 31 is a normal read. Arithmetic is only the `ptr` wrap, mod `NREQ`.
- Simultaneous requests: exactly one is accepted per cycle. Losers keep `req` high and are not acknowledged.
- A requester may re-request in the cycle after its acceptance. It then loses to any other pending requester, because `ptr` has moved past it.
- `hold` asserted mid-stream: already-accepted reads still return. Acceptance resumes from the unchanged `ptr` when `hold` drops.

## Timing
- Reset values: `ptr`=0, `sram_adr`=0, `vA`=0, `tagA`=0, `rvalid`=0.
- Outputs during reset: `gnt` stays combinational but is forced to 0 while `rst_n`=0. `rdata` follows `sram_data` and is not reset.
- Reset mid-operation: all in-flight reads are discarded and their `rvalid` never asserts. After `rst_n` deasserts, the first acceptance is no earlier than the first rising edge.
- Latency: if a request is accepted on edge E0, `rvalid`/`rdata` are valid in the cycle after E0+1 edge. That is, the data is sampled by the requester on edge E0+2.
- Throughput: one read per cycle sustained. Up to 2 reads are in flight.
- `gnt` is purely combinational from `req`, `hold`, `ptr` and `rst_n`. There is no combinational path from `sram_data` to `gnt`.

## Test plan
All scenarios use an `sram` loaded with mem[a] = 32'hA5A5_0000 + a.

1. Single requester: `req`=4'b0100 with address 5 at edge E0. Expect `gnt`=4'b0100 before E0, `sram_adr`=5 after E0, and `rvalid`=4'b0100 with `rdata`=32'hA5A5_0005 in the cycle after E0+1. `rvalid`=0 on every other cycle.
2. Full contention from reset: `req`=4'b1111 held, with addresses 10, 11, 12, 13.
   - Acceptance order is 0,1,2,3,0,… on consecutive edges.
   - `rvalid` sequence is 0001,0010,0100,1000 starting 2 cycles later, with `rdata` 32'hA5A5_000A..000D.
3. Back-to-back same requester: requester 2 alone issues addresses 31, 0, 1 on three consecutive edges. Expect `rdata` 32'hA5A5_001F, 32'hA5A5_0000, 32'hA5A5_0001 on three consecutive cycles, each with `rvalid`=4'b0100.
4. Hold: `req`=4'b0011 with `hold`=1 for 3 cycles, immediately after one acceptance of requester 0.
   - Expect `gnt`=0 for those 3 cycles.
   - The pending read still returns.
   - After `hold`=0, requester 1 is accepted first.
5. Reset mid-flight: accept requester 3, address 7, then pull `rst_n` low asynchronously one cycle later, between edges. Expect `rvalid`=0 immediately and for the remainder, `sram_adr`=0, and `ptr`=0 (the next contention `req`=4'b1001 grants requester 0).
6. Fairness: requester 0 is always requesting while requesters 1..3 request randomly for 1000 cycles. Expect every request accepted within 4 accepting cycles, and every `rdata` to match mem[adr] at its `rvalid`.
